// File: rtl/msg_pkg.sv
// Shared types and constants for the message-to-byte serializer.
package msg_pkg;

  localparam int MSG_BITS_DEF = 32;
  localparam int BYTE_BITS    = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  function automatic int num_bytes(input int msg_bits);
    return msg_bits / BYTE_BITS;
  endfunction

endpackage

// File: rtl/msg_serializer.sv
// Serializes one MSG_BITS-wide message into a stream of bytes over valid/ready.
// Integration note: msg_ready_o depends combinationally on byte_ready_i while sending.
module msg_serializer
  import msg_pkg::*;
#(
  parameter int MSG_BITS  = MSG_BITS_DEF,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [MSG_BITS-1:0] msg_i,
  input  logic                msg_valid_i,
  output logic                msg_ready_o,
  output logic [7:0]          byte_o,
  output logic                byte_valid_o,
  input  logic                byte_ready_i,
  output logic                byte_last_o,
  output logic                busy_o
);

  localparam int NUM_BYTES = num_bytes(MSG_BITS);
  localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

  if (((MSG_BITS % BYTE_BITS) != 0) || (MSG_BITS < BYTE_BITS)) begin : g_bad_width
    $error("msg_serializer: MSG_BITS must be a non-zero multiple of 8");
  end

  ser_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MSG_BITS-1:0] shift_q, shift_d;
  logic                on_last;
  logic [7:0]          head_byte;

  assign on_last   = (cnt_q == LAST_CNT);
  assign head_byte = MSB_FIRST ? shift_q[MSG_BITS-1 -: BYTE_BITS] : shift_q[BYTE_BITS-1:0];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    msg_ready_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        msg_ready_o = 1'b1;
        if (msg_valid_i) begin
          shift_d = msg_i;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        // A new message can only enter as the last byte of the current one leaves.
        msg_ready_o = on_last && byte_ready_i;
        if (byte_ready_i) begin
          if (!on_last) begin
            shift_d = MSB_FIRST ? (shift_q << BYTE_BITS) : (shift_q >> BYTE_BITS);
            cnt_d   = cnt_q + CNT_W'(1);
          end else if (msg_valid_i) begin
            shift_d = msg_i;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o       = (state_q == SEND);
  assign byte_valid_o = (state_q == SEND);
  assign byte_o       = (state_q == SEND) ? head_byte : 8'h00;
  assign byte_last_o  = (state_q == SEND) && on_last;

endmodule

// File: tb/tb_msg_serializer.sv
// Bench for msg_serializer: directed vector table, hand sequences and a queue-based random model.
module tb_msg_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] msg;
  logic        mv;
  logic        br;

  wire  [7:0]  byte_w [3];
  wire  [2:0]  bv_w, bl_w, mr_w, bz_w;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  msg_serializer #(.MSG_BITS(32), .MSB_FIRST(1'b0)) dut_lsb (
    .clk_i(clk), .rst_n_i(rst_n), .msg_i(msg), .msg_valid_i(mv), .msg_ready_o(mr_w[0]),
    .byte_o(byte_w[0]), .byte_valid_o(bv_w[0]), .byte_ready_i(br), .byte_last_o(bl_w[0]),
    .busy_o(bz_w[0]));

  msg_serializer #(.MSG_BITS(32), .MSB_FIRST(1'b1)) dut_msb (
    .clk_i(clk), .rst_n_i(rst_n), .msg_i(msg), .msg_valid_i(mv), .msg_ready_o(mr_w[1]),
    .byte_o(byte_w[1]), .byte_valid_o(bv_w[1]), .byte_ready_i(br), .byte_last_o(bl_w[1]),
    .busy_o(bz_w[1]));

  msg_serializer #(.MSG_BITS(8), .MSB_FIRST(1'b0)) dut_one (
    .clk_i(clk), .rst_n_i(rst_n), .msg_i(msg[7:0]), .msg_valid_i(mv), .msg_ready_o(mr_w[2]),
    .byte_o(byte_w[2]), .byte_valid_o(bv_w[2]), .byte_ready_i(br), .byte_last_o(bl_w[2]),
    .busy_o(bz_w[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; mv = 1'b0; br = 1'b0; msg = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_valid%0d", k), {31'd0, bv_w[k]}, 0);
      chk($sformatf("rst_byte%0d", k),  {24'd0, byte_w[k]}, 0);
      chk($sformatf("rst_last%0d", k),  {31'd0, bl_w[k]}, 0);
      chk($sformatf("rst_busy%0d", k),  {31'd0, bz_w[k]}, 0);
      chk($sformatf("rst_ready%0d", k), {31'd0, mr_w[k]}, 1);
    end
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        mv;
    logic [31:0] msg;
    logic        br;
    logic        e_v;
    logic [7:0]  e_b_lsb;
    logic [7:0]  e_b_msb;
    logic        e_last;
    logic        e_rdy;
  } vec_t;

  vec_t tbl[18];

  // Reference model state: bytes still to be emitted by each instance, in wire order.
  logic [7:0] mq [3][$];
  int         nb_of [3] = '{4, 4, 1};
  bit         msb_of[3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    rst_n = 1'b1; mv = 1'b0; br = 1'b0; msg = '0;

    tbl[0]  = '{1, 32'hA1B2C3D4, 1, 0, 8'h00, 8'h00, 0, 1};
    tbl[1]  = '{0, 32'h0,        1, 1, 8'hD4, 8'hA1, 0, 0};
    tbl[2]  = '{0, 32'h0,        0, 1, 8'hC3, 8'hB2, 0, 0};
    tbl[3]  = '{0, 32'h0,        0, 1, 8'hC3, 8'hB2, 0, 0};
    tbl[4]  = '{0, 32'h0,        0, 1, 8'hC3, 8'hB2, 0, 0};
    tbl[5]  = '{0, 32'h0,        1, 1, 8'hC3, 8'hB2, 0, 0};
    tbl[6]  = '{0, 32'h0,        1, 1, 8'hB2, 8'hC3, 0, 0};
    tbl[7]  = '{0, 32'h0,        1, 1, 8'hA1, 8'hD4, 1, 1};
    tbl[8]  = '{1, 32'h11223344, 1, 0, 8'h00, 8'h00, 0, 1};
    tbl[9]  = '{1, 32'h55667788, 1, 1, 8'h44, 8'h11, 0, 0};
    tbl[10] = '{1, 32'h55667788, 1, 1, 8'h33, 8'h22, 0, 0};
    tbl[11] = '{1, 32'h55667788, 1, 1, 8'h22, 8'h33, 0, 0};
    tbl[12] = '{1, 32'h55667788, 1, 1, 8'h11, 8'h44, 1, 1};
    tbl[13] = '{0, 32'h0,        1, 1, 8'h88, 8'h55, 0, 0};
    tbl[14] = '{0, 32'h0,        1, 1, 8'h77, 8'h66, 0, 0};
    tbl[15] = '{0, 32'h0,        1, 1, 8'h66, 8'h77, 0, 0};
    tbl[16] = '{0, 32'h0,        1, 1, 8'h55, 8'h88, 1, 1};
    tbl[17] = '{0, 32'h0,        1, 0, 8'h00, 8'h00, 0, 1};

    do_reset();

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      mv = tbl[i].mv; msg = tbl[i].msg; br = tbl[i].br;
      #1;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("tbl%0d_valid%0d", i, k), {31'd0, bv_w[k]}, {31'd0, tbl[i].e_v});
        chk($sformatf("tbl%0d_busy%0d", i, k),  {31'd0, bz_w[k]}, {31'd0, tbl[i].e_v});
        chk($sformatf("tbl%0d_ready%0d", i, k), {31'd0, mr_w[k]}, {31'd0, tbl[i].e_rdy});
        chk($sformatf("tbl%0d_last%0d", i, k),  {31'd0, bl_w[k]}, {31'd0, tbl[i].e_last});
        if (tbl[i].e_v)
          chk($sformatf("tbl%0d_byte%0d", i, k), {24'd0, byte_w[k]},
              {24'd0, (k == 0) ? tbl[i].e_b_lsb : tbl[i].e_b_msb});
      end
    end

    // Single-byte messages back to back: one message per cycle, last on every byte.
    do_reset();
    @(negedge clk);
    mv = 1'b1; br = 1'b1; msg = 32'h0000_005A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      msg = 32'(8'h60 + i);
      #1;
      chk($sformatf("one%0d_byte", i),  {24'd0, byte_w[2]}, (i == 0) ? 32'h5A : 32'(8'h60 + i - 1));
      chk($sformatf("one%0d_valid", i), {31'd0, bv_w[2]}, 1);
      chk($sformatf("one%0d_last", i),  {31'd0, bl_w[2]}, 1);
      chk($sformatf("one%0d_ready", i), {31'd0, mr_w[2]}, 1);
    end

    // Asynchronous reset in the middle of a message.
    do_reset();
    @(negedge clk);
    mv = 1'b1; br = 1'b1; msg = 32'hA1B2C3D4;
    @(negedge clk);
    mv = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_byte_before", {24'd0, byte_w[0]}, 32'hC3);
    @(negedge clk);
    #2;
    chk("mid_byte_b2", {24'd0, byte_w[0]}, 32'hB2);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, bv_w[0]}, 0);
    chk("arst_byte",  {24'd0, byte_w[0]}, 0);
    chk("arst_busy",  {31'd0, bz_w[0]}, 0);
    chk("arst_ready", {31'd0, mr_w[0]}, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post_rst%0d_valid", i), {31'd0, bv_w[0]}, 0);
      chk($sformatf("post_rst%0d_ready", i), {31'd0, mr_w[0]}, 1);
    end

    // Randomized traffic against the queue model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      mv  = ($urandom_range(0, 99) < 50);
      br  = ($urandom_range(0, 99) < 70);
      msg = $urandom;
      #1;
      for (int k = 0; k < 3; k++) begin
        int   sz;
        logic e_rdy;
        sz    = mq[k].size();
        e_rdy = (sz == 0) || (sz == 1 && br);
        chk($sformatf("rnd_valid%0d", k), {31'd0, bv_w[k]}, {31'd0, sz != 0});
        chk($sformatf("rnd_busy%0d", k),  {31'd0, bz_w[k]}, {31'd0, sz != 0});
        chk($sformatf("rnd_ready%0d", k), {31'd0, mr_w[k]}, {31'd0, e_rdy});
        if (sz != 0) begin
          chk($sformatf("rnd_byte%0d", k), {24'd0, byte_w[k]}, {24'd0, mq[k][0]});
          chk($sformatf("rnd_last%0d", k), {31'd0, bl_w[k]}, {31'd0, sz == 1});
        end
        if (sz != 0 && br) void'(mq[k].pop_front());
        if (mv && e_rdy)
          for (int j = 0; j < nb_of[k]; j++) begin
            int idx;
            idx = msb_of[k] ? (nb_of[k] - 1 - j) : j;
            mq[k].push_back(msg[idx*8 +: 8]);
          end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
